// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: state codes, opcodes,
// ALU op codes, mux select codes and the DECODE dispatch helper.
// Contents: localparams only plus one pure function; no ports.
package ctrl_pkg;

  // State encodings (visible on the state output, so they are fixed).
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_RTYPE_1 = 4'd3;
  localparam logic [3:0] S_RTYPE_2 = 4'd4;
  localparam logic [3:0] S_BRANCH  = 4'd5;
  localparam logic [3:0] S_JUMP    = 4'd6;
  localparam logic [3:0] S_MEMADD  = 4'd7;
  localparam logic [3:0] S_LW_1    = 4'd8;
  localparam logic [3:0] S_LW_2    = 4'd9;
  localparam logic [3:0] S_SW      = 4'd10;
  localparam logic [3:0] S_ADDI_1  = 4'd11;
  localparam logic [3:0] S_ADDI_2  = 4'd12;
  localparam logic [3:0] S_TRAP    = 4'd13;

  // Opcodes (low six bits of the IR opcode field).
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_BRANCH = 6'b000001;
  localparam logic [5:0] OP_JUMP   = 6'b000010;
  localparam logic [5:0] OP_LW     = 6'b000011;
  localparam logic [5:0] OP_ADDI   = 6'b000100;
  localparam logic [5:0] OP_SW     = 6'b000101;

  // ALU operation codes.
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // ALU B-input selects.
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source selects.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // DECODE successor; any nonzero upper opcode bit makes the opcode illegal.
  function automatic logic [3:0] dispatch(input logic [5:0] op_lo, input logic op_hi_zero);
    logic [3:0] nxt;
    nxt = S_TRAP;
    if (op_hi_zero) begin
      case (op_lo)
        OP_RTYPE:     nxt = S_RTYPE_1;
        OP_BRANCH:    nxt = S_BRANCH;
        OP_JUMP:      nxt = S_JUMP;
        OP_LW, OP_SW: nxt = S_MEMADD;
        OP_ADDI:      nxt = S_ADDI_1;
        default:      nxt = S_TRAP;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ctrl_word_decode.sv
// Purpose: state -> datapath control word (pure Moore decode, no gating).
// Latency: combinational, zero cycles.
// Backpressure: none; FETCH ir_write/pc_write are qualified by the parent.
// Ports: state (in, 4) ; every datapath control signal (out).
module ctrl_word_decode
  import ctrl_pkg::*;
(
  input  logic [3:0] state,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source
);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = 1'b1;
        pc_write  = 1'b1;
      end
      S_DECODE:  alu_src_b = SRCB_IMM_SH;
      S_RTYPE_1: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_RTYPE_2: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_MEMADD, S_ADDI_1: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_LW_1: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_LW_2: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_SW: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_ADDI_2:  reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Purpose: multicycle CPU control unit: state register, opcode dispatch, retire counter.
// Latency: Moore outputs from state; FETCH ir_write/pc_write follow mem_ready same cycle.
// Backpressure: FETCH, LW_1 and SW hold while mem_ready is low (unless MEM_WAIT_EN=0).
// Ports: clk, rst (async high), start, op, mem_ready in; state, control word,
//        busy, illegal_op, retired out.
module multicycle_control_fsm #(
  parameter int OP_W        = 6,
  parameter int CNT_W       = 16,
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic             mem_ready,
  output logic [3:0]       state,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             busy,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);
  import ctrl_pkg::*;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             mem_rdy_eff;
  logic             op_hi_zero;
  logic             op_is_lw;
  logic             retire_evt;
  logic             dec_pc_write, dec_ir_write;

  assign mem_rdy_eff = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign op_hi_zero  = ((op >> 6) == '0);
  assign op_is_lw    = op_hi_zero && (op[5:0] == OP_LW);

  // State register and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_FETCH;
      S_FETCH:   if (mem_rdy_eff) state_d = S_DECODE;
      S_DECODE:  state_d = dispatch(op[5:0], op_hi_zero);
      S_RTYPE_1: state_d = S_RTYPE_2;
      S_RTYPE_2, S_LW_2, S_ADDI_2, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_MEMADD:  state_d = op_is_lw ? S_LW_1 : S_SW;
      S_LW_1:    if (mem_rdy_eff) state_d = S_LW_2;
      S_SW:      if (mem_rdy_eff) state_d = S_FETCH;
      S_ADDI_1:  state_d = S_ADDI_2;
      S_TRAP:    if (start) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Every entry into FETCH other than from IDLE (or a FETCH stall) ends an instruction.
  always_comb begin
    retire_evt = (state_d == S_FETCH) && (state_q != S_FETCH) && (state_q != S_IDLE);
    retired_d  = retire_evt ? retired_q + CNT_W'(1) : retired_q;
  end

  ctrl_word_decode u_dec (
    .state         (state_q),
    .pc_write      (dec_pc_write),
    .pc_write_cond (pc_write_cond),
    .ir_write      (dec_ir_write),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source)
  );

  // Output logic: only the FETCH writes wait on memory; JUMP's pc_write is unconditional.
  always_comb begin
    ir_write   = dec_ir_write & ((state_q != S_FETCH) | mem_rdy_eff);
    pc_write   = dec_pc_write & ((state_q != S_FETCH) | mem_rdy_eff);
    busy       = (state_q != S_IDLE) && (state_q != S_TRAP);
    illegal_op = (state_q == S_TRAP);
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  // Architectural state numbers as published on the state output.
  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_R1 = 3, ST_R2 = 4,
                 ST_BR = 5, ST_J = 6, ST_MA = 7, ST_LW1 = 8, ST_LW2 = 9, ST_SW = 10,
                 ST_AD1 = 11, ST_AD2 = 12, ST_TRAP = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // DUT 0: default timing, 8-bit opcode field (upper-bit legality).
  logic       start0, rdy0;
  logic [7:0] op0;
  logic [3:0] state0;
  logic pcw0, pcwc0, irw0, iord0, mr0, mw0, rw0, rd0, m2r0, asa0, busy0, ill0;
  logic [1:0] asb0, aop0, pcs0;
  logic [15:0] ret0;

  // DUT 1: memory waits disabled, mem_ready tied low.
  logic       start1;
  logic [5:0] op1;
  logic [3:0] state1;
  logic pcw1, pcwc1, irw1, iord1, mr1, mw1, rw1, rd1, m2r1, asa1, busy1, ill1;
  logic [1:0] asb1, aop1, pcs1;
  logic [15:0] ret1;

  // DUT 2: 2-bit retire counter.
  logic       start2;
  logic [5:0] op2;
  logic [3:0] state2;
  logic pcw2, pcwc2, irw2, iord2, mr2, mw2, rw2, rd2, m2r2, asa2, busy2, ill2;
  logic [1:0] asb2, aop2, pcs2;
  logic [1:0] ret2;

  multicycle_control_fsm #(.OP_W(8), .CNT_W(16), .MEM_WAIT_EN(1'b1)) u0 (
    .clk(clk), .rst(rst), .start(start0), .op(op0), .mem_ready(rdy0), .state(state0),
    .pc_write(pcw0), .pc_write_cond(pcwc0), .ir_write(irw0), .iord(iord0),
    .mem_read(mr0), .mem_write(mw0), .reg_write(rw0), .reg_dst(rd0), .mem_to_reg(m2r0),
    .alu_src_a(asa0), .alu_src_b(asb0), .alu_op(aop0), .pc_source(pcs0),
    .busy(busy0), .illegal_op(ill0), .retired(ret0));

  multicycle_control_fsm #(.OP_W(6), .CNT_W(16), .MEM_WAIT_EN(1'b0)) u1 (
    .clk(clk), .rst(rst), .start(start1), .op(op1), .mem_ready(1'b0), .state(state1),
    .pc_write(pcw1), .pc_write_cond(pcwc1), .ir_write(irw1), .iord(iord1),
    .mem_read(mr1), .mem_write(mw1), .reg_write(rw1), .reg_dst(rd1), .mem_to_reg(m2r1),
    .alu_src_a(asa1), .alu_src_b(asb1), .alu_op(aop1), .pc_source(pcs1),
    .busy(busy1), .illegal_op(ill1), .retired(ret1));

  multicycle_control_fsm #(.OP_W(6), .CNT_W(2), .MEM_WAIT_EN(1'b1)) u2 (
    .clk(clk), .rst(rst), .start(start2), .op(op2), .mem_ready(1'b1), .state(state2),
    .pc_write(pcw2), .pc_write_cond(pcwc2), .ir_write(irw2), .iord(iord2),
    .mem_read(mr2), .mem_write(mw2), .reg_write(rw2), .reg_dst(rd2), .mem_to_reg(m2r2),
    .alu_src_a(asa2), .alu_src_b(asb2), .alu_op(aop2), .pc_source(pcs2),
    .busy(busy2), .illegal_op(ill2), .retired(ret2));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Control word {pcw,pcwc,irw,iord,mr,mw,rw,rd,m2r,asa,asb,aop,pcs} the table demands.
  function automatic logic [15:0] exp_ctrl(input int st, input logic rdy);
    logic pcw, pcwc, irw, iord, mr, mw, rw, rd, m2r, asa;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, irw, iord, mr, mw, rw, rd, m2r, asa} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      ST_FETCH:       begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      ST_DECODE:      asb = 2'b11;
      ST_R1:          begin asa = 1; aop = 2'b10; end
      ST_R2:          begin rw = 1; rd = 1; end
      ST_MA, ST_AD1:  begin asa = 1; asb = 2'b10; end
      ST_LW1:         begin mr = 1; iord = 1; end
      ST_LW2:         begin rw = 1; m2r = 1; end
      ST_SW:          begin mw = 1; iord = 1; end
      ST_AD2:         rw = 1;
      ST_BR:          begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      ST_J:           begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, irw, iord, mr, mw, rw, rd, m2r, asa, asb, aop, pcs};
  endfunction

  logic [15:0] act_ctrl0;
  assign act_ctrl0 = {pcw0, pcwc0, irw0, iord0, mr0, mw0, rw0, rd0, m2r0, asa0, asb0, aop0, pcs0};

  // Expected view of DUT 0 for the current cycle.
  bit exp_vld = 0;
  bit inc_pending = 0;
  int exp_state = ST_IDLE;
  int exp_retired = 0;

  always @(negedge clk) begin
    if (exp_vld) begin
      check("state", {28'd0, state0}, exp_state);
      check("ctrl", {16'd0, act_ctrl0}, {16'd0, exp_ctrl(exp_state, rdy0)});
      check("busy", {31'd0, busy0}, {31'd0, (exp_state != ST_IDLE) && (exp_state != ST_TRAP)});
      check("illegal_op", {31'd0, ill0}, {31'd0, exp_state == ST_TRAP});
      check("retired", {16'd0, ret0}, exp_retired);
    end
  end

  // One cycle of DUT 0: drive inputs and declare the state it must be in.
  task automatic step(input int st, input logic rdy, input logic strt);
    @(posedge clk);
    #2;
    if (inc_pending) begin
      exp_retired = exp_retired + 1;
      inc_pending = 0;
    end
    rdy0 = rdy;
    start0 = strt;
    exp_state = st;
    exp_vld = 1;
  endtask

  // Occupy a state; waiting states see `waits` cycles of mem_ready low first.
  task automatic play(input int st, input int waits);
    bit is_wait;
    is_wait = (st == ST_FETCH) || (st == ST_LW1) || (st == ST_SW);
    for (int i = 0; i < waits; i++) step(st, 1'b0, 1'($urandom_range(0, 1)));
    step(st, is_wait ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Whole instruction from FETCH; an illegal opcode ends in one TRAP cycle.
  task automatic run_instr(input logic [7:0] op, input int wf, input int wm);
    int path[$];
    logic [7:0] hi;
    hi = op & 8'hC0;
    op0 = op;
    play(ST_FETCH, wf);
    play(ST_DECODE, 0);
    if (hi != 0 || op[5:0] > 6'd5) begin
      step(ST_TRAP, 1'b1, 1'b0);
      return;
    end
    case (op[5:0])
      6'd0: path = '{ST_R1, ST_R2};
      6'd1: path = '{ST_BR};
      6'd2: path = '{ST_J};
      6'd3: path = '{ST_MA, ST_LW1, ST_LW2};
      6'd4: path = '{ST_AD1, ST_AD2};
      default: path = '{ST_MA, ST_SW};
    endcase
    foreach (path[i]) play(path[i], (path[i] == ST_LW1 || path[i] == ST_SW) ? wm : 0);
    inc_pending = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int lat;
  int ops1[4] = '{0, 4, 1, 2};
  int lats1[4] = '{4, 4, 3, 3};
  int seq2[5] = '{1, 2, 3, 0, 1};

  initial begin
    rst = 1; start0 = 0; rdy0 = 0; op0 = 0;
    start1 = 0; op1 = 0; start2 = 0; op2 = 6'b000010;
    #1;
    check("reset_state", {28'd0, state0}, 0);
    check("reset_ctrl", {16'd0, act_ctrl0}, 0);
    check("reset_retired", {16'd0, ret0}, 0);
    #11 rst = 0;

    step(ST_IDLE, 1'b1, 1'b0);
    step(ST_IDLE, 1'b1, 1'b1);
    run_instr(8'b000011, 0, 0);   // LW: 1,2,7,8,9
    run_instr(8'b000000, 2, 0);   // RTYPE with FETCH stall
    run_instr(8'b000100, 0, 0);   // ADDI
    run_instr(8'b000001, 0, 0);   // BRANCH
    run_instr(8'b000010, 1, 0);   // JUMP
    run_instr(8'b000101, 0, 3);   // SW held 4 cycles
    run_instr(8'b000011, 1, 2);   // LW with stalls
    run_instr(8'b111111, 0, 0);   // illegal -> TRAP
    #1;
    check("trap_retired", {16'd0, ret0}, 7);
    check("trap_flag", {30'd0, ill0, busy0}, 2);
    step(ST_TRAP, 1'b1, 1'b0);
    step(ST_TRAP, 1'b0, 1'b1);
    step(ST_IDLE, 1'b1, 1'b0);
    step(ST_IDLE, 1'b1, 1'b1);
    run_instr(8'b0100_0000, 0, 0); // upper opcode bit set -> TRAP
    step(ST_TRAP, 1'b1, 1'b1);
    step(ST_IDLE, 1'b1, 1'b1);
    run_instr(8'b000010, 0, 0);   // JUMP -> 8 retired

    // Abort a load in LW_1.
    op0 = 8'b000011;
    play(ST_FETCH, 0);
    play(ST_DECODE, 0);
    play(ST_MA, 0);
    step(ST_LW1, 1'b0, 1'b0);
    step(ST_LW1, 1'b0, 1'b0);
    #1;
    check("pre_abort_retired", {16'd0, ret0}, 8);
    rst = 1;
    exp_state = ST_IDLE; exp_retired = 0; inc_pending = 0;
    #1;
    check("abort_state", {28'd0, state0}, 0);
    check("abort_ctrl", {16'd0, act_ctrl0}, 0);
    check("abort_retired", {16'd0, ret0}, 0);
    @(posedge clk);
    #2 start0 = 1;
    #2 rst = 0;
    run_instr(8'b000000, 0, 0);
    step(ST_FETCH, 1'b0, 1'b0);
    #1;
    check("post_abort_retired", {16'd0, ret0}, 1);
    exp_vld = 0;

    // No memory waits: latencies with mem_ready tied low.
    @(posedge clk); #2 start1 = 1;
    @(posedge clk); #2 start1 = 0;
    check("nowait_fetch", {28'd0, state1}, ST_FETCH);
    check("nowait_irw", {30'd0, irw1, pcw1}, 3);
    foreach (ops1[k]) begin
      op1 = 6'(ops1[k]);
      lat = 0;
      do begin
        @(posedge clk); #2;
        lat++;
      end while (state1 != 4'(ST_FETCH) && lat < 16);
      check($sformatf("nowait_lat%0d", k), lat, lats1[k]);
    end
    check("nowait_retired", {16'd0, ret1}, 4);

    // 2-bit counter wrap across JUMPs.
    @(posedge clk); #2 start2 = 1;
    @(posedge clk); #2 start2 = 0;
    check("wrap_start", {30'd0, ret2}, 0);
    foreach (seq2[k]) begin
      lat = 0;
      do begin
        @(posedge clk); #2;
        lat++;
      end while (state2 != 4'(ST_FETCH) && lat < 16);
      check($sformatf("wrap_lat%0d", k), lat, 3);
      check($sformatf("wrap_ret%0d", k), {30'd0, ret2}, seq2[k]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
